decode_queue: RTL and testbench
===============================

# decode_queue

Parametrised instruction queue with integrated MIPS decoder, sitting between fetch and the issue/execute stage of the mycpu pipeline. Fetch pushes (pc, instr) pairs through a valid/ready handshake. The block buffers up to DEPTH entries and presents the head entry fully decoded: register indices, immediate, 12-bit control word, branch class and illegal flag. Buffering decouples fetch stalls from backend stalls, and a single-cycle flush discards wrong-path instructions on redirect.

## Interface
- DEPTH, 4, queue entries; power of two, ≥ 2
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high (fixed)
- flush  in  1  discard all entries
- in_valid  in  1  fetch offers an entry
- in_ready  out  1  queue accepts the entry
- in_pc  in  32  PC of the offered instruction
- in_instr  in  32  instruction word
- out_valid  out  1  head entry is valid
- out_ready  in  1  consumer takes the head
- out_pc  out  32  head PC
- out_rs, out_rt  out  5  instr[25:21], instr[20:16]
- out_rd  out  5  destination register: 0, rd, rt or 31
- out_shamt  out  5  instr[10:6]
- out_shamt_var  out  1  SLLV/SRAV/SRLV; consumer substitutes vs[4:0]
- out_imm  out  32  immediate per imm_type
- out_ctrl  out  12  [11] reg_write, [10:9] strobe, [8] mem_ext, [7] alu_shamt, [6] alu_imm, [5:2] alu_funct, [1] memtoreg, [0] memwrite
- out_br_type  out  4  branch class
- out_illegal  out  1  reserved/unsupported encoding
- count  out  $clog2(DEPTH)+1  occupancy

## Operation
- Storage is a circular buffer with write pointer wp, read pointer rp and occupancy count. Pointers wrap modulo DEPTH.
- Push occurs when in_valid & in_ready. Pop occurs when out_valid & out_ready.
- in_ready = (count < DEPTH) | out_ready. When full, a simultaneous pop and push is allowed and count stays at DEPTH.
- Decoding is combinational on the head entry:
  - imm_type 00 gives ext(imm16), with sign- or zero-extension per opcode.
  - imm_type 01 gives imm16<<16.
  - imm_type 10 gives ext<<2.
  - imm_type 11 gives pc+8 (JAL, JALR, BLTZAL, BGEZAL).
- out_br_type encodings: 0 none, 1 BEQ, 2 BNE, 3 BGTZ, 4 BLEZ, 5 BLTZ, 6 BGEZ, 7 BLTZAL, 8 BGEZAL, 9 J, 10 JAL, 11 JR, 12 JALR. Other codes are reserved.
- Branch conditions are not evaluated here; the consumer resolves them.
- out_illegal = 1 with out_ctrl = 0 for any opcode/funct/REGIMM-rt outside the supported set: ALU R-type, immediate ALU, LUI, loads/stores B/H/W, jumps, branches.
- When out_valid = 0, all out_* data outputs are don't-care.

## Timing
- Reset: wp = rp = 0, count = 0, out_valid = 0, in_ready = 1.
- Latency: an entry pushed at edge N is presented at out in cycle N+1. This is zero-cycle with bypass; see Configuration.
- Throughput: one push and one pop per cycle, sustained.
- Flush: at the next edge, count = 0 and wp = rp = 0. Any push or pop in the flush cycle is ignored. During flush, out_valid is forced to 0 and in_ready is forced to 0.
- Reset has priority over flush. Reset mid-stream drops everything.
- Empty with only a push: count becomes 1. Full with only a pop: count becomes DEPTH-1.
- Pointer wrap from DEPTH-1 to 0 is seamless, with no bubble.

## Configuration
- DECODE_QUEUE_BYPASS_EN defined: when count = 0 and in_valid and no flush, the incoming entry is decoded and presented combinationally the same cycle (out_valid = 1).
  - If out_ready is also high, the entry is consumed without being written, and count stays 0.
  - Otherwise it is written normally.
- DECODE_QUEUE_BYPASS_EN undefined: no in-to-out combinational path; minimum latency is 1 cycle.

## Structure
- Shared package decode_pkg holds:
  - opcode, funct and REGIMM-rt constants
  - br_type_t enum
  - ctrl field positions
  - imm_type / reg_dst encodings
- Sub-module decode_core is purely combinational. It maps (pc, instr) to rs, rt, rd, shamt, shamt_var, imm, ctrl, br_type, illegal. It is instantiated once, fed by the head entry, or by the input when bypassing.

## Test plan
- Reset, push ADDIU (0x2408FFFF, pc 0x1000) → next cycle: out_rd = 8, out_imm = 0xFFFFFFFF, out_ctrl[11] = 1, out_ctrl[6] = 1, count = 1.
- Push JAL at pc 0x2000 → out_rd = 31, out_imm = 0x2008, out_br_type = 10. Push BGEZAL → out_br_type = 8, out_rd = 31.
- Hold out_ready = 0 and push 5 entries with DEPTH = 4 → in_ready falls after 4 pushes and count = 4. Then assert out_ready with in_valid for 8 cycles → entries drain in order, count holds 4, pointers wrap.
- Fill 3 entries, assert flush together with in_valid and out_ready → next cycle count = 0, out_valid = 0, the pushed entry is not stored.
- Push instr 0xFC000000 → out_illegal = 1, out_ctrl = 0. Push SRAV → out_shamt_var = 1.
- With DECODE_QUEUE_BYPASS_EN on an empty queue, in_valid and out_ready → out_valid = 1 in the same cycle, count stays 0. Without the macro, out_valid rises one cycle later.

Source files
------------

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared MIPS decode constants, control word layout and helpers
// Purpose: opcode/funct/REGIMM-rt constants, branch class enum, control word
//          struct, immediate type and destination register encodings.
// Ports:   none (package).
package decode_pkg;
  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02, OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c, OP_ORI    = 6'h0d, OP_XORI = 6'h0e, OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24, OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03, FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR   = 6'h08, FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20, FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24, FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a, FN_SLTU = 6'h2b;

  localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11;

  typedef enum logic [3:0] {
    BR_NONE = 4'd0, BR_BEQ = 4'd1, BR_BNE = 4'd2, BR_BGTZ = 4'd3, BR_BLEZ = 4'd4,
    BR_BLTZ = 4'd5, BR_BGEZ = 4'd6, BR_BLTZAL = 4'd7, BR_BGEZAL = 4'd8,
    BR_J = 4'd9, BR_JAL = 4'd10, BR_JR = 4'd11, BR_JALR = 4'd12
  } br_type_t;

  // Field order fixes the bit positions of the 12-bit control word (MSB first).
  typedef struct packed {
    logic       reg_write;  // [11]
    logic [1:0] strobe;     // [10:9]
    logic       mem_ext;    // [8]  sign-extend load data
    logic       alu_shamt;  // [7]  shift by shamt (consumer swaps in vs for *V shifts)
    logic       alu_imm;    // [6]  ALU B operand is out_imm
    logic [3:0] alu_funct;  // [5:2]
    logic       memtoreg;   // [1]
    logic       memwrite;   // [0]
  } ctrl_t;

  localparam logic [1:0] STB_NONE = 2'b00, STB_BYTE = 2'b01, STB_HALF = 2'b10, STB_WORD = 2'b11;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_SRA = 4'd10;
  // Result = B operand; used by LUI and by links, where out_imm already holds pc+8.
  localparam logic [3:0] ALU_PASSB = 4'd11;

  localparam logic [1:0] IMM_EXT = 2'b00, IMM_LUI = 2'b01, IMM_BR = 2'b10, IMM_LINK = 2'b11;
  localparam logic [1:0] RD_ZERO = 2'b00, RD_RD = 2'b01, RD_RT = 2'b10, RD_RA = 2'b11;

  function automatic logic [31:0] ext16(input logic [15:0] v, input logic zext);
    return zext ? {16'h0000, v} : {{16{v[15]}}, v};
  endfunction
endpackage

// File: rtl/decode_core.sv
// rtl/decode_core.sv - combinational MIPS decoder for one (pc, instr) pair
// Purpose: map an instruction to register indices, immediate, control word,
//          branch class and illegal flag.
// Ports:   i_pc, i_instr in; o_rs, o_rt, o_rd, o_shamt, o_shamt_var, o_imm,
//          o_ctrl, o_br_type, o_illegal out.
module decode_core
  import decode_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  output logic [4:0]  o_rs,
  output logic [4:0]  o_rt,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_shamt,
  output logic        o_shamt_var,
  output logic [31:0] o_imm,
  output logic [11:0] o_ctrl,
  output logic [3:0]  o_br_type,
  output logic        o_illegal
);
  logic [5:0]  w_op, w_fn;
  logic [15:0] w_imm16;
  logic [31:0] w_ext;
  ctrl_t       w_ctrl;
  br_type_t    w_br;
  logic [1:0]  w_imm_type, w_reg_dst;
  logic        w_zext, w_svar, w_ill;

  assign w_op    = i_instr[31:26];
  assign w_fn    = i_instr[5:0];
  assign w_imm16 = i_instr[15:0];
  assign o_rs    = i_instr[25:21];
  assign o_rt    = i_instr[20:16];
  assign o_shamt = i_instr[10:6];

  always_comb begin
    w_ctrl = '0; w_br = BR_NONE; w_imm_type = IMM_EXT; w_reg_dst = RD_ZERO;
    w_zext = 1'b0; w_svar = 1'b0; w_ill = 1'b0;
    case (w_op)
      OP_SPECIAL: begin
        w_reg_dst = RD_RD;
        case (w_fn)
          FN_SLL:  begin w_ctrl.alu_shamt = 1'b1; w_ctrl.alu_funct = ALU_SLL; end
          FN_SRL:  begin w_ctrl.alu_shamt = 1'b1; w_ctrl.alu_funct = ALU_SRL; end
          FN_SRA:  begin w_ctrl.alu_shamt = 1'b1; w_ctrl.alu_funct = ALU_SRA; end
          FN_SLLV: begin w_ctrl.alu_shamt = 1'b1; w_ctrl.alu_funct = ALU_SLL; w_svar = 1'b1; end
          FN_SRLV: begin w_ctrl.alu_shamt = 1'b1; w_ctrl.alu_funct = ALU_SRL; w_svar = 1'b1; end
          FN_SRAV: begin w_ctrl.alu_shamt = 1'b1; w_ctrl.alu_funct = ALU_SRA; w_svar = 1'b1; end
          FN_JR:   begin w_reg_dst = RD_ZERO; w_br = BR_JR; end
          FN_JALR: begin
            w_br = BR_JALR; w_imm_type = IMM_LINK;
            w_ctrl.alu_imm = 1'b1; w_ctrl.alu_funct = ALU_PASSB;
          end
          FN_ADD, FN_ADDU: w_ctrl.alu_funct = ALU_ADD;
          FN_SUB, FN_SUBU: w_ctrl.alu_funct = ALU_SUB;
          FN_AND:  w_ctrl.alu_funct = ALU_AND;
          FN_OR:   w_ctrl.alu_funct = ALU_OR;
          FN_XOR:  w_ctrl.alu_funct = ALU_XOR;
          FN_NOR:  w_ctrl.alu_funct = ALU_NOR;
          FN_SLT:  w_ctrl.alu_funct = ALU_SLT;
          FN_SLTU: w_ctrl.alu_funct = ALU_SLTU;
          default: w_ill = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        w_imm_type = IMM_BR;
        case (o_rt)
          RT_BLTZ:   w_br = BR_BLTZ;
          RT_BGEZ:   w_br = BR_BGEZ;
          RT_BLTZAL: w_br = BR_BLTZAL;
          RT_BGEZAL: w_br = BR_BGEZAL;
          default:   w_ill = 1'b1;
        endcase
        if (o_rt == RT_BLTZAL || o_rt == RT_BGEZAL) begin
          w_imm_type = IMM_LINK; w_reg_dst = RD_RA;
          w_ctrl.alu_imm = 1'b1; w_ctrl.alu_funct = ALU_PASSB;
        end
      end
      OP_J:   w_br = BR_J;
      OP_JAL: begin
        w_br = BR_JAL; w_imm_type = IMM_LINK; w_reg_dst = RD_RA;
        w_ctrl.alu_imm = 1'b1; w_ctrl.alu_funct = ALU_PASSB;
      end
      OP_BEQ:  begin w_br = BR_BEQ;  w_imm_type = IMM_BR; end
      OP_BNE:  begin w_br = BR_BNE;  w_imm_type = IMM_BR; end
      OP_BLEZ: begin w_br = BR_BLEZ; w_imm_type = IMM_BR; end
      OP_BGTZ: begin w_br = BR_BGTZ; w_imm_type = IMM_BR; end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        w_reg_dst = RD_RT; w_ctrl.alu_imm = 1'b1;
        case (w_op)
          OP_SLTI:  w_ctrl.alu_funct = ALU_SLT;
          OP_SLTIU: w_ctrl.alu_funct = ALU_SLTU;
          OP_ANDI:  begin w_ctrl.alu_funct = ALU_AND; w_zext = 1'b1; end
          OP_ORI:   begin w_ctrl.alu_funct = ALU_OR;  w_zext = 1'b1; end
          OP_XORI:  begin w_ctrl.alu_funct = ALU_XOR; w_zext = 1'b1; end
          OP_LUI:   begin w_ctrl.alu_funct = ALU_PASSB; w_imm_type = IMM_LUI; end
          default:  w_ctrl.alu_funct = ALU_ADD;
        endcase
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        w_reg_dst = RD_RT; w_ctrl.alu_imm = 1'b1; w_ctrl.memtoreg = 1'b1;
        w_ctrl.mem_ext = (w_op == OP_LB) || (w_op == OP_LH);
        w_ctrl.strobe  = (w_op == OP_LW) ? STB_WORD :
                         (w_op == OP_LH || w_op == OP_LHU) ? STB_HALF : STB_BYTE;
      end
      OP_SB, OP_SH, OP_SW: begin
        w_ctrl.alu_imm = 1'b1; w_ctrl.memwrite = 1'b1;
        w_ctrl.strobe  = (w_op == OP_SW) ? STB_WORD : (w_op == OP_SH) ? STB_HALF : STB_BYTE;
      end
      default: w_ill = 1'b1;
    endcase
    // Unsupported encodings decode to a harmless bubble.
    if (w_ill) begin
      w_ctrl = '0; w_br = BR_NONE; w_imm_type = IMM_EXT; w_reg_dst = RD_ZERO;
      w_zext = 1'b0; w_svar = 1'b0;
    end
    w_ctrl.reg_write = (w_reg_dst != RD_ZERO);
    if (w_ctrl.strobe == STB_NONE) w_ctrl.mem_ext = 1'b0;
  end

  assign w_ext = ext16(w_imm16, w_zext);

  always_comb begin
    case (w_imm_type)
      IMM_LUI:  o_imm = {w_imm16, 16'h0000};
      IMM_BR:   o_imm = {w_ext[29:0], 2'b00};
      IMM_LINK: o_imm = i_pc + 32'd8;
      default:  o_imm = w_ext;
    endcase
    case (w_reg_dst)
      RD_RD:   o_rd = i_instr[15:11];
      RD_RT:   o_rd = o_rt;
      RD_RA:   o_rd = 5'd31;
      default: o_rd = 5'd0;
    endcase
  end

  assign o_shamt_var = w_svar;
  assign o_ctrl      = w_ctrl;
  assign o_br_type   = w_br;
  assign o_illegal   = w_ill;
endmodule

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - instruction queue presenting a fully decoded head entry
// Purpose: circular buffer of DEPTH (pc, instr) entries between fetch and issue,
//          with single-cycle flush; head is decoded by decode_core.
// Ports:   clk, reset (sync, active-high), flush; in_valid/in_ready/in_pc/in_instr
//          from fetch; out_valid/out_ready and decoded out_* fields to issue; count.
// Option:  DECODE_QUEUE_BYPASS_EN - present an entry arriving at an empty queue
//          in the same cycle.
module decode_queue
  import decode_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [4:0]               out_rs,
  output logic [4:0]               out_rt,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_shamt,
  output logic                     out_shamt_var,
  output logic [31:0]              out_imm,
  output logic [11:0]              out_ctrl,
  output logic [3:0]               out_br_type,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]   r_pc    [DEPTH];
  logic [31:0]   r_instr [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_count;

  logic        w_empty, w_full, w_bypass, w_push, w_pop, w_wr, w_rd;
  logic [31:0] w_head_pc, w_head_instr;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(DEPTH));

`ifdef DECODE_QUEUE_BYPASS_EN
  assign w_bypass = w_empty & in_valid & ~flush;
`else
  assign w_bypass = 1'b0;
`endif

  assign out_valid = ~flush & (~w_empty | w_bypass);
  assign in_ready  = ~flush & (~w_full | out_ready);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  // A bypassed entry taken the same cycle never touches storage.
  assign w_wr      = w_push & ~(w_bypass & out_ready);
  assign w_rd      = w_pop & ~w_bypass;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_pc[r_wp]    <= in_pc;
      r_instr[r_wp] <= in_instr;
    end
  end

  assign w_head_pc    = w_bypass ? in_pc    : r_pc[r_rp];
  assign w_head_instr = w_bypass ? in_instr : r_instr[r_rp];
  assign out_pc       = w_head_pc;
  assign count        = r_count;

  decode_core u_decode_core (
    .i_pc        (w_head_pc),
    .i_instr     (w_head_instr),
    .o_rs        (out_rs),
    .o_rt        (out_rt),
    .o_rd        (out_rd),
    .o_shamt     (out_shamt),
    .o_shamt_var (out_shamt_var),
    .o_imm       (out_imm),
    .o_ctrl      (out_ctrl),
    .o_br_type   (out_br_type),
    .o_illegal   (out_illegal)
  );
endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - self-checking bench for decode_queue
module tb_decode_queue;
  localparam int DEPTH = 4;
`ifdef DECODE_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_instr, out_pc, out_imm;
  logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
  logic        out_shamt_var, out_illegal;
  logic [11:0] out_ctrl;
  logic [3:0]  out_br_type;
  logic [2:0]  count;

  always #5 clk = ~clk;

  decode_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_shamt(out_shamt),
    .out_shamt_var(out_shamt_var), .out_imm(out_imm), .out_ctrl(out_ctrl),
    .out_br_type(out_br_type), .out_illegal(out_illegal), .count(count)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [11:0] ctrl;
    logic [3:0]  br;
    logic        ill;
    logic        sv;
  } vec_t;

  vec_t        vt [20];
  int          mq[$];
  int          cur;
  int          checks = 0;
  int          failures = 0;
  bit          run_cmp = 1'b0;
  bit          m_ov, m_ir, m_push, m_pop;
  int          head;
  logic [31:0] ins;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic setv(input int i, input logic [31:0] pc, input logic [31:0] instr,
                      input logic [4:0] rd, input logic [31:0] imm, input logic [11:0] ctrl,
                      input logic [3:0] br, input logic ill, input logic sv);
    vt[i] = '{pc: pc, instr: instr, rd: rd, imm: imm, ctrl: ctrl, br: br, ill: ill, sv: sv};
  endtask

  task automatic drive(input bit v, input int idx, input bit ordy, input bit fl);
    @(posedge clk);
    #1;
    in_valid  = v;
    cur       = idx;
    in_pc     = vt[idx].pc;
    in_instr  = vt[idx].instr;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Queue-level model: entries are vector indices, order is FIFO.
  always @(posedge clk) begin
    if (reset || flush) begin
      mq.delete();
    end else begin
      m_ov   = (mq.size() > 0) || (BYP && in_valid);
      m_ir   = (mq.size() < DEPTH) || out_ready;
      m_push = in_valid && m_ir;
      m_pop  = m_ov && out_ready;
      if (!(m_pop && mq.size() == 0)) begin
        if (m_pop) void'(mq.pop_front());
        if (m_push) mq.push_back(cur);
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp && !reset) begin
      m_ov = !flush && ((mq.size() > 0) || (BYP && in_valid));
      m_ir = !flush && ((mq.size() < DEPTH) || out_ready);
      chk("count", 32'(count), 32'(mq.size()));
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      chk("in_ready", 32'(in_ready), 32'(m_ir));
      if (m_ov) begin
        head = (mq.size() > 0) ? mq[0] : cur;
        ins  = vt[head].instr;
        chk("out_pc", out_pc, vt[head].pc);
        chk("out_rs", 32'(out_rs), 32'(ins[25:21]));
        chk("out_rt", 32'(out_rt), 32'(ins[20:16]));
        chk("out_shamt", 32'(out_shamt), 32'(ins[10:6]));
        chk("out_rd", 32'(out_rd), 32'(vt[head].rd));
        chk("out_imm", out_imm, vt[head].imm);
        chk("out_ctrl", 32'(out_ctrl), 32'(vt[head].ctrl));
        chk("out_br_type", 32'(out_br_type), 32'(vt[head].br));
        chk("out_illegal", 32'(out_illegal), 32'(vt[head].ill));
        chk("out_shamt_var", 32'(out_shamt_var), 32'(vt[head].sv));
      end
    end
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cur = 0; in_pc = '0; in_instr = '0;
    //      idx pc           instr         rd  imm           ctrl    br ill sv
    setv( 0, 32'h1000, 32'h2408FFFF,  8, 32'hFFFFFFFF, 12'h840,  0, 0, 0); // ADDIU
    setv( 1, 32'h2000, 32'h0C000100, 31, 32'h00002008, 12'h86C, 10, 0, 0); // JAL
    setv( 2, 32'h2004, 32'h04910004, 31, 32'h0000200C, 12'h86C,  8, 0, 0); // BGEZAL
    setv( 3, 32'h3000, 32'h1022FFFE,  0, 32'hFFFFFFF8, 12'h000,  1, 0, 0); // BEQ
    setv( 4, 32'h3004, 32'h3C091234,  9, 32'h12340000, 12'h86C,  0, 0, 0); // LUI
    setv( 5, 32'h3008, 32'h352A8001, 10, 32'h00008001, 12'h84C,  0, 0, 0); // ORI
    setv( 6, 32'h300C, 32'h83ABFFFC, 11, 32'hFFFFFFFC, 12'hB42,  0, 0, 0); // LB
    setv( 7, 32'h3010, 32'hACC50008,  0, 32'h00000008, 12'h641,  0, 0, 0); // SW
    setv( 8, 32'h3014, 32'h00851823,  3, 32'h00001823, 12'h804,  0, 0, 0); // SUBU
    setv( 9, 32'h3018, 32'h01283807,  7, 32'h00003807, 12'h8A8,  0, 0, 1); // SRAV
    setv(10, 32'h301C, 32'h00031140,  2, 32'h00001140, 12'h8A0,  0, 0, 0); // SLL
    setv(11, 32'h4000, 32'h0080F809, 31, 32'h00004008, 12'h86C, 12, 0, 0); // JALR
    setv(12, 32'h4004, 32'h03E00008,  0, 32'h00000008, 12'h000, 11, 0, 0); // JR
    setv(13, 32'h4008, 32'hFC000000,  0, 32'h00000000, 12'h000,  0, 1, 0); // bad opcode
    setv(14, 32'h5000, 32'h04400001,  0, 32'h00000004, 12'h000,  5, 0, 0); // BLTZ
    setv(15, 32'h5004, 32'h28A4FFFF,  4, 32'hFFFFFFFF, 12'h858,  0, 0, 0); // SLTI
    setv(16, 32'h5008, 32'h0000000C,  0, 32'h0000000C, 12'h000,  0, 1, 0); // SYSCALL
    setv(17, 32'h500C, 32'h04020000,  0, 32'h00000000, 12'h000,  0, 1, 0); // bad REGIMM rt
    setv(18, 32'h5010, 32'h942C0002, 12, 32'h00000002, 12'hC42,  0, 0, 0); // LHU
    setv(19, 32'h5014, 32'h08000010,  0, 32'h00000010, 12'h000,  9, 0, 0); // J

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    run_cmp = 1'b1;

    // ADDIU appears one cycle after its push.
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("addiu_rd", 32'(out_rd), 32'd8);
    chk("addiu_imm", out_imm, 32'hFFFFFFFF);
    chk("addiu_regwrite", 32'(out_ctrl[11]), 32'd1);
    chk("addiu_aluimm", 32'(out_ctrl[6]), 32'd1);
    chk("addiu_count", 32'(count), 32'd1);

    // JAL then BGEZAL.
    drive(0, 0, 1, 0);
    drive(1, 1, 1, 0);
    drive(1, 2, 0, 0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("jal_rd", 32'(out_rd), 32'd31);
    chk("jal_imm", out_imm, 32'h2008);
    chk("jal_br", 32'(out_br_type), 32'd10);
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("bgezal_br", 32'(out_br_type), 32'd8);
    chk("bgezal_rd", 32'(out_rd), 32'd31);
    drive(0, 0, 1, 0);

    // Fill past capacity with the consumer stalled.
    for (int i = 0; i < 5; i++) drive(1, 3 + i, 0, 0);
    @(negedge clk);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(count), 32'd4);

    // Full-rate push+pop while full; pointers wrap twice.
    for (int i = 0; i < 8; i++) drive(1, 7 + i, 1, 0);
    @(negedge clk);
    chk("stream_count", 32'(count), 32'd4);

    // Down to 3 entries, then flush with a push and pop offered.
    drive(0, 0, 1, 0);
    drive(1, 15, 1, 1);
    @(negedge clk);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("post_flush_count", 32'(count), 32'd0);
    chk("post_flush_valid", 32'(out_valid), 32'd0);

    // Illegal encoding and variable shift.
    drive(1, 13, 0, 0);
    drive(1, 9, 0, 0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("illegal_flag", 32'(out_illegal), 32'd1);
    chk("illegal_ctrl", 32'(out_ctrl), 32'd0);
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("srav_shamt_var", 32'(out_shamt_var), 32'd1);
    drive(0, 0, 1, 0);

    // Remaining encodings streamed with the consumer always ready.
    for (int i = 15; i < 20; i++) drive(1, i, 1, 0);
    repeat (3) drive(0, 0, 1, 0);

    // Empty queue, push with consumer ready: same-cycle only with bypass.
    drive(1, 4, 1, 0);
    @(negedge clk);
    chk("byp_same_cycle_valid", 32'(out_valid), 32'(BYP));
    chk("byp_same_cycle_count", 32'(count), 32'd0);
    drive(0, 0, 1, 0);
    @(negedge clk);
    chk("byp_next_cycle_valid", 32'(out_valid), 32'(!BYP));
    drive(0, 0, 0, 0);

    // Reset mid-stream drops everything.
    drive(1, 5, 0, 0);
    drive(1, 6, 0, 0);
    drive(0, 0, 0, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    repeat (2) drive(0, 0, 0, 0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
